// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold time and a one-cycle gap between grants.
// Grant is registered one edge after the request is sampled; a grantee keeps the resource until it drops its request or MAX_HOLD expires.

module Or8Way (
    input  logic [7:0] in_i,
    output logic       out_o
);
    assign out_o = |in_i;
endmodule

module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_i,
    output logic [7:0] grant_o,
    output logic [2:0] grant_id_o,
    output logic       busy_o,
    output logic       any_req_o,
    output logic       timeout_o
);
    localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q;
    logic [2:0]    ptr_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    grant_q;
    logic [2:0]    grant_id_q;
    logic          busy_q;
    logic          timeout_q;

    logic          any_req;
    logic [2:0]    win_d;
    logic [2:0]    scan_idx;
    logic          found;

    Or8Way u_or8way (
        .in_i  (req_i),
        .out_o (any_req)
    );

    assign any_req_o = any_req;

    // Scan starts just above the last grantee so it ends up with lowest priority.
    always_comb begin
        win_d    = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!found && req_i[scan_idx]) begin
                found = 1'b1;
                win_d = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd7;
            cnt_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= GRANT;
                        grant_q    <= 8'b1 << win_d;
                        grant_id_q <= win_d;
                        busy_q     <= 1'b1;
                        cnt_q      <= CW'(1);
                    end
                end
                GRANT: begin
                    // Release wins over timeout when both happen on the same edge.
                    if (!req_i[grant_id_q]) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= grant_id_q;
                    end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LIM)) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        ptr_q     <= grant_id_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: one instance with MAX_HOLD=4, one with the timeout disabled.
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req0;

    logic [7:0] grant, grant0;
    logic [2:0] gid, gid0;
    logic       busy, busy0, anyr, anyr0, tmo, tmo0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .grant_o(grant), .grant_id_o(gid), .busy_o(busy),
        .any_req_o(anyr), .timeout_o(tmo)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0),
        .grant_o(grant0), .grant_id_o(gid0), .busy_o(busy0),
        .any_req_o(anyr0), .timeout_o(tmo0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                             input logic eb, input logic et);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_id"},    32'(gid),   32'(eid));
        chk({tag, "_busy"},  32'(busy),  32'(eb));
        chk({tag, "_tmo"},   32'(tmo),   32'(et));
    endtask

    logic [7:0] or_vec [6] = '{8'h00, 8'h01, 8'hA0, 8'hDF, 8'h00, 8'hFF};
    logic       or_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [2:0] g;
        logic [2:0] nxt;
        rst  = 1'b1;
        req  = 8'h00;
        req0 = 8'h00;
        tick();
        tick();
        chk_grant("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_grant("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset priority: requester 0 wins over 7
        req = 8'b1000_0001;
        tick();
        chk_grant("reset_prio", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'b1000_0000;
        tick();
        chk_grant("release0", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        chk_grant("grant7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_grant("release7", 8'h00, 3'd7, 1'b0, 1'b0);

        // Rotation 0..7,0 with one idle cycle between grants
        req = 8'hFF;
        tick();
        chk_grant("rot_first", 8'h01, 3'd0, 1'b1, 1'b0);
        g = 3'd0;
        for (int k = 0; k < 8; k++) begin
            req = 8'hFF & ~(8'b1 << g);
            tick();
            chk_grant("rot_gap", 8'h00, g, 1'b0, 1'b0);
            req = 8'hFF;
            tick();
            nxt = g + 3'd1;
            chk_grant("rot_grant", 8'b1 << nxt, nxt, 1'b1, 1'b0);
            g = nxt;
        end
        req = 8'h00;
        tick();
        chk_grant("rot_end", 8'h00, 3'd0, 1'b0, 1'b0);

        // Timeout with a single requester: 4 grant cycles, gap with pulse, re-grant
        req = 8'b0000_0100;
        tick();
        chk_grant("to_c1", 8'h04, 3'd2, 1'b1, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk_grant("to_hold", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        tick();
        chk_grant("to_revoke", 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        chk_grant("to_regrant", 8'h04, 3'd2, 1'b1, 1'b0);

        // Timeout with a competitor: next grant goes to 3
        req = 8'b0000_1100;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk_grant("to2_hold", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        tick();
        chk_grant("to2_revoke", 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        chk_grant("to2_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_grant("to2_release", 8'h00, 3'd3, 1'b0, 1'b0);

        // Wrap-around from ptr=6
        req = 8'b0100_0000;
        tick();
        chk_grant("wrap_set6", 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        req = 8'b0100_0010;
        tick();
        chk_grant("wrap_grant1", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'b0100_0000;
        tick();
        chk_grant("wrap_gap", 8'h00, 3'd1, 1'b0, 1'b0);
        req = 8'b0100_0010;
        tick();
        chk_grant("wrap_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        // Reset mid-grant
        req = 8'b0010_0000;
        tick();
        chk_grant("mid_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_grant("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 8'b0010_0001;
        tick();
        chk_grant("mid_after", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        // Combinational any-request path
        for (int k = 0; k < 6; k++) begin
            req = or_vec[k];
            #1;
            chk("any_req", 32'(anyr), 32'(or_exp[k]));
        end
        req = 8'h00;

        // Timeout disabled: grant held for 100 cycles
        req0 = 8'h01;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("nohold_grant", 32'(grant0), 32'h01);
            chk("nohold_tmo",   32'(tmo0),   32'h0);
        end
        req0 = 8'h00;
        tick();
        chk("nohold_release_busy", 32'(busy0), 32'h0);
        chk("nohold_release_tmo",  32'(tmo0),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
